// File: rtl/phoenix_pkg.sv
// Shared types and default frame counts for the coin/start sequencer.
package phoenix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COIN,
    ST_GAP,
    ST_START,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_1P,
    SEL_2P
  } sel_t;

  localparam int DEF_COIN_FRAMES  = 4;
  localparam int DEF_GAP_FRAMES   = 8;
  localparam int DEF_START_FRAMES = 4;

  function automatic logic [1:0] sel_to_btn(input sel_t s);
    case (s)
      SEL_1P:  return 2'b01;
      SEL_2P:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/coin_start_ctrl.sv
// Turns player start / coin requests into frame-timed coin pulses followed by
// a start-button press toward the core, timed off vblank rising edges.
module coin_start_ctrl
  import phoenix_pkg::*;
#(
  parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
  parameter int GAP_FRAMES   = DEF_GAP_FRAMES,
  parameter int START_FRAMES = DEF_START_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vblank,
  input  logic [1:0] start_req,
  input  logic       coin_req,
  output logic       btn_coin,
  output logic [1:0] btn_player_start,
  output logic       busy
);

  if (COIN_FRAMES < 1 || COIN_FRAMES > 15) begin : g_bad_coin
    $error("coin_start_ctrl: COIN_FRAMES must be 1..15");
  end
  if (GAP_FRAMES < 1 || GAP_FRAMES > 15) begin : g_bad_gap
    $error("coin_start_ctrl: GAP_FRAMES must be 1..15");
  end
  if (START_FRAMES < 1 || START_FRAMES > 15) begin : g_bad_start
    $error("coin_start_ctrl: START_FRAMES must be 1..15");
  end

  localparam logic [3:0] COIN_N  = 4'(COIN_FRAMES);
  localparam logic [3:0] GAP_N   = 4'(GAP_FRAMES);
  localparam logic [3:0] START_N = 4'(START_FRAMES);

  logic       armed;
  logic       vblank_q;
  logic [1:0] start_q;
  logic       coin_q;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] coins_left, coins_n;
  sel_t       sel, sel_n;
  logic       coin_n;
  logic [1:0] start_btn_n;
  logic       busy_n;

  logic       tick;
  logic [1:0] start_edge;
  logic       coin_edge;

  // armed masks the first clk after reset so levels held through reset are
  // captured into the copies instead of being seen as fresh edges.
  assign tick       = armed & vblank & ~vblank_q;
  assign start_edge = {2{armed}} & start_req & ~start_q;
  assign coin_edge  = armed & coin_req & ~coin_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    coins_n = coins_left;
    sel_n   = sel;

    case (state)
      ST_IDLE: begin
        cnt_n = 4'd0;
        if (start_edge[1]) begin
          coins_n = 2'd2;
          sel_n   = SEL_2P;
          state_n = ST_COIN;
        end else if (start_edge[0]) begin
          coins_n = 2'd1;
          sel_n   = SEL_1P;
          state_n = ST_COIN;
        end else if (coin_edge) begin
          coins_n = 2'd1;
          sel_n   = SEL_NONE;
          state_n = ST_COIN;
        end
      end
      ST_COIN: begin
        if (cnt == COIN_N) begin
          coins_n = coins_left - 2'd1;
          state_n = ST_GAP;
        end else if (tick) begin
          cnt_n = cnt + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_N) begin
          if (coins_left != 2'd0)  state_n = ST_COIN;
          else if (sel != SEL_NONE) state_n = ST_START;
          else                      state_n = ST_IDLE;
        end else if (tick) begin
          cnt_n = cnt + 4'd1;
        end
      end
      ST_START: begin
        if (cnt == START_N) state_n = ST_RELEASE;
        else if (tick)      cnt_n = cnt + 4'd1;
      end
      ST_RELEASE: begin
        cnt_n = 4'd0;
        if (start_req == 2'b00 && !coin_req) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // Every state starts its frame count from zero; a tick on the entry clk
    // is deliberately lost.
    if (state_n != state) cnt_n = 4'd0;

    coin_n      = (state_n == ST_COIN);
    start_btn_n = (state_n == ST_START) ? sel_to_btn(sel_n) : 2'b00;
    busy_n      = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed            <= 1'b0;
      vblank_q         <= 1'b0;
      start_q          <= 2'b00;
      coin_q           <= 1'b0;
      state            <= ST_IDLE;
      cnt              <= 4'd0;
      coins_left       <= 2'd0;
      sel              <= SEL_NONE;
      btn_coin         <= 1'b0;
      btn_player_start <= 2'b00;
      busy             <= 1'b0;
    end else begin
      armed            <= 1'b1;
      vblank_q         <= vblank;
      start_q          <= start_req;
      coin_q           <= coin_req;
      state            <= state_n;
      cnt              <= cnt_n;
      coins_left       <= coins_n;
      sel              <= sel_n;
      btn_coin         <= coin_n;
      btn_player_start <= start_btn_n;
      busy             <= busy_n;
    end
  end

endmodule

// File: tb/tb_coin_start_ctrl.sv
// Directed bench: samples {btn_coin, btn_player_start} once per frame tick and
// compares against hand-written per-frame sequences.
module tb_coin_start_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank = 1'b0;
  logic [1:0] start_req = 2'b00;
  logic       coin_req = 1'b0;
  logic       btn_coin;
  logic [1:0] btn_player_start;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [2:0] flog[$];
  logic [2:0] exp_q[$];
  bit         log_en = 1'b0;
  event       tick_ev;

  coin_start_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .vblank           (vblank),
    .start_req        (start_req),
    .coin_req         (coin_req),
    .btn_coin         (btn_coin),
    .btn_player_start (btn_player_start),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Free-running frames of 100 clk; outputs are logged in the tick cycle,
  // i.e. the state the DUT holds while that tick is being counted.
  initial begin : vgen
    forever begin
      repeat (80) @(posedge clk);
      #1 vblank = 1'b1;
      @(negedge clk);
      if (log_en) flog.push_back({btn_coin, btn_player_start});
      ->tick_ev;
      repeat (20) @(posedge clk);
      #1 vblank = 1'b0;
    end
  end

  function automatic void add(logic [2:0] v, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  task automatic wait_frames(int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic mid_frame();
    @(tick_ev);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({btn_coin, btn_player_start, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0000", {btn_coin, btn_player_start, busy});
    end
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_1p_held();
    mid_frame();
    flog.delete(); exp_q.delete();
    add(3'b100, 4); add(3'b000, 8); add(3'b001, 4); add(3'b000, 4);
    log_en = 1'b1;
    start_req = 2'b01;
    wait_frames(20);
    log_en = 1'b0;
    tests++;
    if (flog.size() != exp_q.size()) begin
      fails++;
      $display("FAIL 1p_log_len: got %0d expected %0d", flog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (flog[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL 1p_frame%0d: got %b expected %b", i, flog[i], exp_q[i]);
        end
      end
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL 1p_release_busy_held: got %b expected 1", busy);
    end
    start_req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL 1p_release_idle: got %b expected 0", busy);
    end
    wait_frames(3);
    tests++;
    if ({btn_coin, busy} !== 2'b00) begin
      fails++;
      $display("FAIL 1p_no_retrigger: got %b expected 00", {btn_coin, busy});
    end
  endtask

  // Shared by the plain 2P test and the simultaneous-edge test.
  task automatic run_2p(logic [1:0] st, logic cn, string nm);
    mid_frame();
    flog.delete(); exp_q.delete();
    add(3'b100, 4); add(3'b000, 8); add(3'b100, 4); add(3'b000, 8);
    add(3'b010, 4); add(3'b000, 4);
    log_en = 1'b1;
    start_req = st;
    coin_req = cn;
    repeat (5) @(posedge clk);
    #1;
    start_req = 2'b00;
    coin_req = 1'b0;
    wait_frames(32);
    log_en = 1'b0;
    tests++;
    if (flog.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_log_len: got %0d expected %0d", nm, flog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (flog[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s_frame%0d: got %b expected %b", nm, i, flog[i], exp_q[i]);
        end
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_end_busy: got %b expected 0", nm, busy);
    end
  endtask

  task automatic test_2p();
    run_2p(2'b10, 1'b0, "2p");
  endtask

  task automatic test_simultaneous();
    run_2p(2'b11, 1'b1, "simul");
  endtask

  task automatic test_coin_only();
    mid_frame();
    flog.delete(); exp_q.delete();
    add(3'b100, 4); add(3'b000, 12);
    log_en = 1'b1;
    coin_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 coin_req = 1'b0;
    wait_frames(16);
    log_en = 1'b0;
    tests++;
    if (flog.size() != exp_q.size()) begin
      fails++;
      $display("FAIL coin_log_len: got %0d expected %0d", flog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (flog[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL coin_frame%0d: got %b expected %b", i, flog[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_coin_during_start();
    mid_frame();
    flog.delete(); exp_q.delete();
    add(3'b100, 4); add(3'b000, 8); add(3'b001, 4); add(3'b000, 8);
    log_en = 1'b1;
    start_req = 2'b01;
    repeat (5) @(posedge clk);
    #1 start_req = 2'b00;
    wait_frames(13);
    tests++;
    if (btn_player_start !== 2'b01) begin
      fails++;
      $display("FAIL cds_in_start: got %b expected 01", btn_player_start);
    end
    repeat (10) @(posedge clk);
    #1 coin_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 coin_req = 1'b0;
    wait_frames(11);
    log_en = 1'b0;
    tests++;
    if (flog.size() != exp_q.size()) begin
      fails++;
      $display("FAIL cds_log_len: got %0d expected %0d", flog.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests++;
        if (flog[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL cds_frame%0d: got %b expected %b", i, flog[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_coin();
    mid_frame();
    start_req = 2'b01;
    wait_frames(2);
    tests++;
    if (btn_coin !== 1'b1) begin
      fails++;
      $display("FAIL rmc_in_coin: got %b expected 1", btn_coin);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({btn_coin, btn_player_start, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL rmc_async_clear: got %b expected 0000", {btn_coin, btn_player_start, busy});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    wait_frames(3);
    tests++;
    if ({btn_coin, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rmc_held_no_start: got %b expected 00", {btn_coin, busy});
    end
    start_req = 2'b00;
    repeat (3) @(posedge clk);
    #1 start_req = 2'b01;
    @(posedge clk);
    #1;
    tests++;
    if ({btn_coin, busy} !== 2'b11) begin
      fails++;
      $display("FAIL rmc_new_edge_starts: got %b expected 11", {btn_coin, busy});
    end
    start_req = 2'b00;
    wait_frames(20);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rmc_end_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_1p_held();
    test_2p();
    test_simultaneous();
    test_coin_only();
    test_coin_during_start();
    test_reset_mid_coin();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coin_start_ctrl.md
COIN_START_CTRL -- requirements
Module: coin_start_ctrl

Interface
REQ-001 Parameter COIN_FRAMES, default 4: frames btn_coin is held per inserted coin.
REQ-002 Parameter GAP_FRAMES, default 8: idle frames after each coin pulse.
REQ-003 Parameter START_FRAMES, default 4: frames the selected start bit is held.
REQ-004 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vblank  input  1  core vertical blank, synchronous to clk; its rising edge is the frame tick.
REQ-007 start_req  input  2  player start requests, level, bit0 = 1P, bit1 = 2P.
REQ-008 coin_req  input  1  dedicated coin request, level.
REQ-009 btn_coin  output  1  coin line to the core, registered.
REQ-010 btn_player_start  output  2  start lines to the core, registered, at most one bit high.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Frame tick SHALL be a one-clk pulse on the cycle after vblank goes 0->1, taken from a registered copy of vblank.
REQ-013 Request edges SHALL be 0->1 transitions of start_req bits and coin_req, detected against registered copies.
REQ-014 The FSM SHALL have the states IDLE, COIN, GAP, START and RELEASE.
REQ-015 IDLE, start_req[1] edge: load coins_left=2 and sel=2P, then go to COIN.
REQ-016 IDLE, start_req[0] edge only: load coins_left=1 and sel=1P, then go to COIN.
REQ-017 IDLE, coin_req edge with no start edge: load coins_left=1 and sel=none, then go to COIN.
REQ-018 On simultaneous edges, priority SHALL be start_req[1] > start_req[0] > coin_req; losing edges SHALL be discarded.
REQ-019 COIN: btn_coin=1; after COIN_FRAMES ticks, decrement coins_left and go to GAP.
REQ-020 GAP: btn_coin=0; after GAP_FRAMES ticks go to COIN if coins_left!=0, else START if sel!=none, else IDLE.
REQ-021 START: btn_player_start[sel]=1; after START_FRAMES ticks go to RELEASE.
REQ-022 RELEASE: all outputs 0; go to IDLE on the first clk where start_req==0 and coin_req==0.
REQ-023 Edges arriving outside IDLE SHALL be discarded; they are not queued.
REQ-024 The frame counter SHALL be 4 bits, SHALL clear on every state entry, and SHALL count ticks only.
REQ-025 A state exits on the clk after the tick that brings the count to its parameter value.
REQ-026 Outputs SHALL be registered and decoded from the next state, so they change in the same clk the state does.
REQ-027 Parameters are legal from 1 to 15; 0 is illegal and SHALL be rejected by an elaboration-time assertion.
REQ-028 A tick coinciding with a state transition SHALL NOT count toward the new state.

Reset
REQ-029 While reset is high: state=IDLE; btn_coin, btn_player_start and busy are 0; counters, coins_left and sel are cleared; registered vblank and request copies are 0.
REQ-030 Reset asserted mid-sequence SHALL drop every output to 0 asynchronously.
REQ-031 After release, the first rising edge of a request still held from before reset SHALL count as a new edge.

Structure
REQ-032 The state enum and default frame-count constants SHALL live in shared package phoenix_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; edge detection is inline.

Verification
REQ-034 start_req=01 held, ticks every 100 clk: btn_coin high 4 ticks, low 8, then btn_player_start=01 for 4 ticks; busy drops after start_req releases.
REQ-035 start_req=10: exactly two 4-tick coin pulses separated by an 8-tick gap, then btn_player_start=10 for 4 ticks.
REQ-036 start_req and coin_req rise in the same clk as 11 / 1: the 2P sequence runs and no extra coin pulse appears.
REQ-037 coin_req pulse during START: ignored; no further btn_coin pulse follows RELEASE.
REQ-038 reset asserted mid-COIN: btn_coin is 0 within the same clk; after release with start_req held at 01, nothing starts until start_req goes 0 then 1.
REQ-039 start_req held at 01 through RELEASE: FSM stays in RELEASE with busy=1 until release, then returns to IDLE without retriggering.
